// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between ALU and load write-back.
// Fixed priority to loads, with the ALU promoted after a run of denied cycles.
module regfile_write_arbiter #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_ready,
   output logic              rf_write_en,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   output logic              prio_alu,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic {
      PRIO_MEM = 1'b0,
      PRIO_ALU = 1'b1
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t      state;
   state_t      state_next;
   logic [3:0]  starve_cnt;
   logic [3:0]  starve_next;
   logic        accept;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Grant selection, starvation tracking and priority transitions.
   // The promotion decision looks at the counter value being written this
   // edge so the ALU gets the port in the cycle right after its Nth denial.
   always_comb begin
      alu_ready   = 1'b0;
      mem_ready   = 1'b0;
      state_next  = state;
      starve_next = starve_cnt;
      if (!rst) begin
         if (state == PRIO_ALU) begin
            if (alu_valid)      alu_ready = 1'b1;
            else if (mem_valid) mem_ready = 1'b1;
         end else begin
            if (mem_valid)      mem_ready = 1'b1;
            else if (alu_valid) alu_ready = 1'b1;
         end
      end
      if (alu_ready)
         starve_next = 4'd0;
      else if (alu_valid)
         starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
      else
         starve_next = 4'd0;
      if (state == PRIO_MEM) begin
         if (starve_next == LIMIT) state_next = PRIO_ALU;
      end else begin
         if (alu_ready) state_next = PRIO_MEM;
      end
   end

   assign accept   = alu_ready | mem_ready;
   assign win_addr = alu_ready ? alu_addr : mem_addr;
   assign win_data = alu_ready ? alu_data : mem_data;
   assign prio_alu = (state == PRIO_ALU);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PRIO_MEM;
         starve_cnt <= 4'd0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
      end
   end

   // Writes to register 0 still move the address/data registers but never enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_write_en   <= 1'b0;
         rf_write_addr <= '0;
         rf_write_data <= '0;
      end else begin
         rf_write_en <= accept && (win_addr != '0);
         if (accept) begin
            rf_write_addr <= win_addr;
            rf_write_data <= win_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         conflict_cnt <= '0;
      else if (alu_valid && mem_valid && (conflict_cnt != '1))
         conflict_cnt <= conflict_cnt + 1'b1;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed checks of regfile_write_arbiter against a
// behavioural model of grant order, write-back contents and counters.
module tb_regfile_write_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int LIMIT  = 4;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              alu_valid = 1'b0;
   logic [ADDR_W-1:0] alu_addr = '0;
   logic [DATA_W-1:0] alu_data = '0;
   logic              alu_ready;
   logic              mem_valid = 1'b0;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [DATA_W-1:0] mem_data = '0;
   logic              mem_ready;
   logic              rf_write_en;
   logic [ADDR_W-1:0] rf_write_addr;
   logic [DATA_W-1:0] rf_write_data;
   logic              prio_alu;
   logic [CNT_W-1:0]  conflict_cnt;

   int assertCount = 0;
   int failCount   = 0;

   // Reference model state: whether the ALU has been promoted, how long it
   // has been denied, the conflict tally and the expected write-port contents.
   bit          m_promoted;
   int          m_streak;
   int          m_conf;
   bit          m_en;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   bit          last_aw;
   bit          last_mw;

   regfile_write_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
      .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .prio_alu(prio_alu), .conflict_cnt(conflict_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                input bit mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md);
      alu_valid = av; alu_addr = aa; alu_data = ad;
      mem_valid = mv; mem_addr = ma; mem_data = md;
   endtask

   task automatic modelReset();
      m_promoted = 0; m_streak = 0; m_conf = 0;
      m_en = 0; m_addr = '0; m_data = '0;
   endtask

   // Called just after a falling edge with inputs applied; checks this
   // cycle's handshake, advances the model, then checks the write port.
   task automatic runCycle();
      bit aw, mw;
      #1;
      aw = alu_valid && (!mem_valid || m_promoted);
      mw = mem_valid && !aw;
      checkOutput("alu_ready", 32'(alu_ready), 32'(aw));
      checkOutput("mem_ready", 32'(mem_ready), 32'(mw));
      checkOutput("prio_alu", 32'(prio_alu), 32'(m_promoted));
      checkOutput("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
      if (aw) begin
         m_streak = 0; m_promoted = 0;
      end else if (alu_valid) begin
         m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
         if (m_streak == LIMIT) m_promoted = 1;
      end else begin
         m_streak = 0;
      end
      if (alu_valid && mem_valid && m_conf < CMAX) m_conf++;
      m_en = 0;
      if (aw) begin
         m_addr = alu_addr; m_data = alu_data; m_en = (alu_addr != 0);
      end else if (mw) begin
         m_addr = mem_addr; m_data = mem_data; m_en = (mem_addr != 0);
      end
      last_aw = aw; last_mw = mw;
      @(posedge clk); #1;
      checkOutput("rf_write_en", 32'(rf_write_en), 32'(m_en));
      checkOutput("rf_write_addr", 32'(rf_write_addr), 32'(m_addr));
      checkOutput("rf_write_data", rf_write_data, m_data);
      @(negedge clk);
   endtask

   // Keeps both requesters busy: a served requester immediately brings new data.
   task automatic refillBoth(input logic [ADDR_W-1:0] aa, input logic [ADDR_W-1:0] ma);
      if (last_aw) alu_data = $urandom;
      if (last_mw) mem_data = $urandom;
      alu_valid = 1; alu_addr = aa;
      mem_valid = 1; mem_addr = ma;
   endtask

   initial begin
      modelReset();
      last_aw = 0; last_mw = 0;
      repeat (2) @(negedge clk);
      checkOutput("reset_rf_en", 32'(rf_write_en), 0);
      checkOutput("reset_prio", 32'(prio_alu), 0);
      checkOutput("reset_conf", 32'(conflict_cnt), 0);
      rst = 1'b0;

      // Lone ALU write, then idle: write appears for exactly one cycle.
      applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, '0, '0);
      runCycle();
      checkOutput("alu_only_data", rf_write_data, 32'hDEADBEEF);
      applyStimulus(0, '0, '0, 0, '0, '0);
      runCycle();

      // Load to register 0: handshake completes, write stays disabled.
      applyStimulus(0, '0, '0, 1, 5'd0, 32'd5);
      runCycle();
      checkOutput("r0_en", 32'(rf_write_en), 0);
      applyStimulus(0, '0, '0, 0, '0, '0);
      runCycle();

      // Same destination from both sides: load first, ALU second.
      applyStimulus(1, 5'd7, 32'd1, 1, 5'd7, 32'd2);
      runCycle();
      checkOutput("same_addr_first", rf_write_data, 32'd2);
      mem_valid = 0;
      runCycle();
      checkOutput("same_addr_second", rf_write_data, 32'd1);
      applyStimulus(0, '0, '0, 0, '0, '0);
      runCycle();

      // Continuous contention: ALU wins every fifth cycle.
      last_aw = 1; last_mw = 1;
      for (int i = 0; i < 14; i++) begin
         refillBoth(5'd1, 5'd2);
         runCycle();
         if (i < 10) checkOutput("starve_pattern", 32'(last_aw), 32'((i % 5) == 4));
      end

      // Mid-stream asynchronous reset while the ALU is promoted.
      refillBoth(5'd1, 5'd2);
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_rf_en", 32'(rf_write_en), 0);
      checkOutput("rst_rf_addr", 32'(rf_write_addr), 0);
      checkOutput("rst_rf_data", rf_write_data, 0);
      checkOutput("rst_prio", 32'(prio_alu), 0);
      checkOutput("rst_conf", 32'(conflict_cnt), 0);
      checkOutput("rst_alu_ready", 32'(alu_ready), 0);
      checkOutput("rst_mem_ready", 32'(mem_ready), 0);
      @(posedge clk); #1;
      checkOutput("rst_no_write", 32'(rf_write_en), 0);
      @(negedge clk);
      rst = 1'b0;
      modelReset();

      // Conflict counter saturation.
      last_aw = 1; last_mw = 1;
      for (int i = 0; i < 20; i++) begin
         refillBoth(5'd9, 5'd10);
         runCycle();
      end
      #1 checkOutput("conf_saturated", 32'(conflict_cnt), CMAX);

      // Random traffic; requests hold their payload until accepted.
      applyStimulus(0, '0, '0, 0, '0, '0);
      last_aw = 0; last_mw = 0;
      for (int i = 0; i < 400; i++) begin
         if (last_aw) alu_valid = 0;
         if (last_mw) mem_valid = 0;
         if (!alu_valid && ($urandom_range(0, 2) != 0)) begin
            alu_valid = 1; alu_addr = ADDR_W'($urandom_range(0, 7)); alu_data = $urandom;
         end
         if (!mem_valid && ($urandom_range(0, 2) != 0)) begin
            mem_valid = 1; mem_addr = ADDR_W'($urandom_range(0, 7)); mem_data = $urandom;
         end
         runCycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
